// File: rtl/sram_like_data_slave_pkg.sv
// Shared definitions for the SRAM-like data slave and the benches that drive it.
package sram_like_data_slave_pkg;

  // Access size encodings carried on the size port.
  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } size_e;

  // Response-entry field widths: {data, wr, cnt}.
  localparam int unsigned DataW   = 32;
  localparam int unsigned StrbW   = DataW / 8;
  localparam int unsigned WrFlagW = 1;

  // Countdown field width; it must hold LAT-1, and at least one bit.
  function automatic int unsigned cnt_width(int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

  // Byte-lane merge of a strobed write into an existing word.
  function automatic logic [DataW-1:0] strb_merge(logic [DataW-1:0] old_word,
                                                  logic [DataW-1:0] new_word,
                                                  logic [StrbW-1:0] strb);
    logic [DataW-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(StrbW); i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_like_data_slave_resp_fifo.sv
// In-order response queue: circular buffer whose entries each count down
// to zero independently; the head is ready once its count reaches zero.
module sram_like_data_slave_resp_fifo
  import sram_like_data_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned OccW = PtrW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [DataW-1:0] i_push_data,
  input  logic             i_push_wr,
  input  logic             i_pop,
  output logic [DataW-1:0] o_head_data,
  output logic             o_head_wr,
  output logic             o_head_ready,
  output logic [OccW-1:0]  o_count
);

  localparam int unsigned     CntW    = cnt_width(LAT);
  localparam logic [CntW-1:0] CntLoad = CntW'(LAT - 1);

  logic [DataW-1:0] r_data [DEPTH];
  logic             r_wr   [DEPTH];
  logic [CntW-1:0]  r_cnt  [DEPTH];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [OccW-1:0]  r_count;

  // Capture the entry payload; only ever read while the slot is occupied.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_data[r_wr_ptr] <= i_push_data;
      r_wr[r_wr_ptr]   <= i_push_wr;
    end
  end

  // Per-slot countdown: load on push, else decrement until zero. Free slots
  // may count down too; they are reloaded before they can become the head.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (i_push && (r_wr_ptr == PtrW'(i))) begin
          r_cnt[i] <= CntLoad;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Pointers wrap naturally; occupancy holds on simultaneous push and pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head view for the top level.
  always_comb begin
    o_head_data  = r_data[r_rd_ptr];
    o_head_wr    = r_wr[r_rd_ptr];
    o_head_ready = (r_count != '0) && (r_cnt[r_rd_ptr] == '0);
    o_count      = r_count;
  end

endmodule

// File: rtl/sram_like_data_slave.sv
// Responder end of the SRAM-like data interface: word array with byte-strobed
// writes, in-order fixed-latency responses, and test back-pressure.
module sram_like_data_slave
  import sram_like_data_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = 2,
  localparam int unsigned OccW  = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic             i_wr,
  input  logic [1:0]       i_size,
  input  logic [StrbW-1:0] i_wstrb,
  input  logic [31:0]      i_addr,
  input  logic [DataW-1:0] i_wdata,
  input  logic             i_addr_stall,
  output logic             o_addr_ok,
  output logic             o_data_ok,
  output logic [DataW-1:0] o_rdata,
  output logic [OccW-1:0]  o_outstanding
);

  localparam int unsigned Words = 1 << ADDR_W;

  logic [DataW-1:0]  r_mem [Words];
  logic [ADDR_W-1:0] w_idx;
  logic [DataW-1:0]  w_rd_word;
  logic              w_hs;
  logic [DataW-1:0]  w_head_data;
  logic              w_head_wr;
  logic              w_head_ready;
  logic [OccW-1:0]   w_count;
  logic              w_unused;

  // Upper address bits alias; size is informational since wstrb governs writes.
  assign w_unused  = ^{i_size, i_addr[31:ADDR_W+2], i_addr[1:0]};
  assign w_idx     = i_addr[ADDR_W+1:2];
  assign w_rd_word = r_mem[w_idx];

  // Acceptance: a full queue can still accept when the head pops this cycle.
  always_comb begin
    o_addr_ok = !i_reset && i_req && !i_addr_stall &&
                ((w_count < OccW'(DEPTH)) || w_head_ready);
    w_hs      = i_req && o_addr_ok;
  end

  // Array update at acceptance, so later queued reads see the new data.
  always_ff @(posedge i_clk) begin
    if (w_hs && i_wr) r_mem[w_idx] <= strb_merge(w_rd_word, i_wdata, i_wstrb);
  end

  sram_like_data_slave_resp_fifo #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) u_resp_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_hs),
    .i_push_data  (w_rd_word),
    .i_push_wr    (i_wr),
    .i_pop        (w_head_ready),
    .o_head_data  (w_head_data),
    .o_head_wr    (w_head_wr),
    .o_head_ready (w_head_ready),
    .o_count      (w_count)
  );

  // Response outputs; write responses and idle cycles return zero data.
  always_comb begin
    o_data_ok     = w_head_ready;
    o_rdata       = (w_head_ready && !w_head_wr) ? w_head_data : '0;
    o_outstanding = w_count;
  end

endmodule
